// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci-type sequence generator.
package fib_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  // Default seeds; sized to WIDTH at the point of use.
  localparam int unsigned FIB_SEED0 = 0;
  localparam int unsigned FIB_SEED1 = 1;

  localparam logic MODE_RESTART = 1'b0;
  localparam logic MODE_HALT    = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for the term index and overflow count.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci-type sequence source with loadable seeds, valid/ready output and overflow handling.
// Define FIB_SEQ_GEN_OVF_CNT_EN to add the saturating ovf_cnt output.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic             mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] number,
  output logic [IDX_W-1:0] index,
  output logic             ovf,
`ifdef FIB_SEQ_GEN_OVF_CNT_EN
  output logic             done,
  output logic [IDX_W-1:0] ovf_cnt
`else
  output logic             done
`endif
);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] cur_d, cur_q;
  logic [WIDTH-1:0] nxt_d, nxt_q;
  logic [WIDTH-1:0] seed0_d, seed0_q;
  logic [WIDTH-1:0] seed1_d, seed1_q;
  logic             pend_d, pend_q;
  logic [WIDTH:0]   sum;
  logic             accept;
  logic             ovf_take;
  logic             idx_inc;
  logic             idx_clr;

  assign sum    = {1'b0, cur_q} + {1'b0, nxt_q};
  assign accept = (state_q == RUN) && out_ready;

  // start wins over a simultaneous accept, which is then dropped.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    nxt_d    = nxt_q;
    seed0_d  = seed0_q;
    seed1_d  = seed1_q;
    pend_d   = pend_q;
    ovf_take = 1'b0;
    idx_inc  = 1'b0;
    idx_clr  = 1'b0;
    if (start) begin
      seed0_d = seed_a;
      seed1_d = seed_b;
      cur_d   = seed_a;
      nxt_d   = seed_b;
      pend_d  = 1'b0;
      state_d = RUN;
      idx_clr = 1'b1;
    end else if (accept) begin
      if (!pend_q) begin
        cur_d   = nxt_q;
        nxt_d   = sum[WIDTH-1:0];
        pend_d  = sum[WIDTH];
        idx_inc = 1'b1;
      end else begin
        ovf_take = 1'b1;
        unique case (mode)
          MODE_RESTART: begin
            cur_d   = seed0_q;
            nxt_d   = seed1_q;
            pend_d  = 1'b0;
            idx_clr = 1'b1;
          end
          MODE_HALT: state_d = HALT;
          default:   state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      seed0_q <= WIDTH'(FIB_SEED0);
      seed1_q <= WIDTH'(FIB_SEED1);
      cur_q   <= WIDTH'(FIB_SEED0);
      nxt_q   <= WIDTH'(FIB_SEED1);
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed0_q <= seed0_d;
      seed1_q <= seed1_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      pend_q  <= pend_d;
    end
  end

  sat_counter #(
    .W (IDX_W)
  ) u_idx_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (idx_clr),
    .inc   (idx_inc),
    .count (index)
  );

`ifdef FIB_SEQ_GEN_OVF_CNT_EN
  sat_counter #(
    .W (IDX_W)
  ) u_ovf_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .inc   (ovf_take),
    .count (ovf_cnt)
  );
`endif

  assign out_valid = (state_q == RUN);
  assign done      = (state_q == HALT);
  assign number    = cur_q;
  assign ovf       = ovf_take && !reset;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen: literal expectations plus a term-level reference model.
module tb_fib_seq_gen;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = 8;
  localparam longint unsigned LIMIT = 64'd1 << WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] seed_a;
  logic [WIDTH-1:0] seed_b;
  logic             mode;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] number;
  logic [IDX_W-1:0] index;
  logic             ovf;
  logic             done;
`ifdef FIB_SEQ_GEN_OVF_CNT_EN
  logic [IDX_W-1:0] ovf_cnt;
`endif

  always #5 clk = ~clk;

  fib_seq_gen #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seed_a    (seed_a),
    .seed_b    (seed_b),
    .mode      (mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .number    (number),
    .index     (index),
    .ovf       (ovf),
`ifdef FIB_SEQ_GEN_OVF_CNT_EN
    .done      (done),
    .ovf_cnt   (ovf_cnt)
`else
    .done      (done)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: seeds, position in the unbounded integer sequence, halted flag, overflow count.
  longint unsigned m_s0 = 0;
  longint unsigned m_s1 = 1;
  int unsigned     m_j  = 0;
  bit              m_halt = 1'b0;
  int unsigned     m_cnt  = 0;
  bit              armed  = 1'b0;

  function automatic longint unsigned term(longint unsigned s0, longint unsigned s1,
                                           int unsigned j);
    longint unsigned a = s0;
    longint unsigned b = s1;
    longint unsigned c;
    for (int unsigned i = 0; i < j; i++) begin
      c = a + b;
      a = b;
      b = c;
    end
    return a;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    bit exp_ovf;
    exp_ovf = !reset && !start && !m_halt && out_ready && (term(m_s0, m_s1, m_j + 1) >= LIMIT);
    chk("m_out_valid", 64'(out_valid), 64'(!m_halt));
    chk("m_done", 64'(done), 64'(m_halt));
    chk("m_number", 64'(number), term(m_s0, m_s1, m_j));
    chk("m_index", 64'(index), 64'(m_j));
    chk("m_ovf", 64'(ovf), 64'(exp_ovf));
`ifdef FIB_SEQ_GEN_OVF_CNT_EN
    chk("m_ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
`endif
  endtask

  task automatic model_update();
    if (reset) begin
      m_s0 = 0; m_s1 = 1; m_j = 0; m_halt = 1'b0; m_cnt = 0;
    end else if (start) begin
      m_s0 = 64'(seed_a); m_s1 = 64'(seed_b); m_j = 0; m_halt = 1'b0; m_cnt = 0;
    end else if (!m_halt && out_ready) begin
      if (term(m_s0, m_s1, m_j + 1) >= LIMIT) begin
        if (m_cnt < 255) m_cnt++;
        if (mode) m_halt = 1'b1;
        else m_j = 0;
      end else if (m_j < 255) begin
        m_j++;
      end
    end
  endtask

  // One clock: compare at the falling edge, advance model at the rising edge.
  task automatic tick();
    @(negedge clk);
    if (armed) model_compare();
    @(posedge clk);
    model_update();
    armed = 1'b1;
    #1;
  endtask

  int fib_lit [14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
  int luc_lit [7]  = '{2, 1, 3, 4, 7, 11, 18};
  bit rdy_pat [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int e;
    reset = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b0;
    seed_a = '0; seed_b = '0;
    tick();
    reset = 1'b0;
    chk("rst_number", 64'(number), 0);
    chk("rst_index", 64'(index), 0);
    chk("rst_valid", 64'(out_valid), 1);
    chk("rst_done", 64'(done), 0);

    // Default stream with wrap back to the seeds.
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      chk("fib_number", 64'(number), 64'(fib_lit[i]));
      chk("fib_index", 64'(index), 64'(i));
      chk("fib_ovf", 64'(ovf), 64'(i == 13));
      tick();
    end
    chk("wrap_number", 64'(number), 0);
    chk("wrap_index", 64'(index), 0);
    chk("wrap_ovf", 64'(ovf), 0);

    // Backpressure pattern 1,0,0,1.
    e = 0;
    for (int k = 0; k < 8; k++) begin
      out_ready = rdy_pat[k % 4];
      chk("bp_number", 64'(number), 64'(fib_lit[e]));
      chk("bp_index", 64'(index), 64'(e));
      tick();
      if (rdy_pat[k % 4]) e++;
    end

    // Halt mode.
    out_ready = 1'b0; start = 1'b1; seed_a = 8'd0; seed_b = 8'd1;
    tick();
    start = 1'b0; mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    chk("halt_pre_number", 64'(number), 233);
    chk("halt_pre_index", 64'(index), 13);
    chk("halt_pre_ovf", 64'(ovf), 1);
    tick();
    chk("halt_valid", 64'(out_valid), 0);
    chk("halt_done", 64'(done), 1);
    chk("halt_number", 64'(number), 233);
    chk("halt_ovf", 64'(ovf), 0);
    repeat (10) tick();
    chk("halt_hold_number", 64'(number), 233);
    chk("halt_hold_index", 64'(index), 13);
    chk("halt_hold_done", 64'(done), 1);
    start = 1'b1; seed_a = 8'd2; seed_b = 8'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("lucas_number", 64'(number), 64'(luc_lit[i]));
      chk("lucas_index", 64'(index), 64'(i));
      tick();
    end

    // start colliding with an accept at index 4.
    mode = 1'b0; start = 1'b1; seed_a = 8'd0; seed_b = 8'd1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("coll_pre_number", 64'(number), 3);
    chk("coll_pre_index", 64'(index), 4);
    start = 1'b1; seed_a = 8'd5; seed_b = 8'd7;
    chk("coll_ovf", 64'(ovf), 0);
    tick();
    start = 1'b0;
    chk("coll_number", 64'(number), 5);
    chk("coll_index", 64'(index), 0);
    tick();
    chk("coll_next", 64'(number), 7);

    // Seeds whose sum carries: overflow on the second accept.
    start = 1'b1; seed_a = 8'd200; seed_b = 8'd100;
    tick();
    start = 1'b0;
    chk("big_t0", 64'(number), 200);
    chk("big_ovf0", 64'(ovf), 0);
    tick();
    chk("big_t1", 64'(number), 100);
    chk("big_idx1", 64'(index), 1);
    chk("big_ovf1", 64'(ovf), 1);
    tick();
    chk("big_restart", 64'(number), 200);
    chk("big_restart_idx", 64'(index), 0);
    tick();
    chk("big_restart_t1", 64'(number), 100);

    // Reset dominating a simultaneous start mid-stream.
    tick();
    reset = 1'b1; start = 1'b1; seed_a = 8'd9; seed_b = 8'd9;
    tick();
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    chk("rs_number", 64'(number), 0);
    chk("rs_index", 64'(index), 0);
    chk("rs_valid", 64'(out_valid), 1);
`ifdef FIB_SEQ_GEN_OVF_CNT_EN
    chk("rs_ovf_cnt", 64'(ovf_cnt), 0);
`endif
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
